// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - angle table, gain constant and FSM state type for cordic_seq (macro CORDIC_SEQ_GAIN_COMP_EN)
package cordic_pkg;

    // atan(2^-i) in units of 2*pi/2^32, rounded to nearest; rescaled per angle width below
    localparam logic [31:0] ATAN_Q32 [32] = '{
        32'd536870912, 32'd316933406, 32'd167458907, 32'd85004756,
        32'd42667331,  32'd21354465,  32'd10679838,  32'd5340245,
        32'd2670163,   32'd1335087,   32'd667544,    32'd333772,
        32'd166886,    32'd83443,     32'd41722,     32'd20861,
        32'd10430,     32'd5215,      32'd2608,      32'd1304,
        32'd652,       32'd326,       32'd163,       32'd81,
        32'd41,        32'd20,        32'd10,        32'd5,
        32'd3,         32'd1,         32'd1,         32'd0
    };

    function automatic logic [31:0] atan_entry(input logic [4:0] i, input int aw);
        logic [32:0] v;
        v = {1'b0, ATAN_Q32[i]};
        if (aw < 32)
            v = (v + (33'd1 << (31 - aw))) >> (32 - aw);
        return v[31:0];
    endfunction

`ifdef CORDIC_SEQ_GAIN_COMP_EN
    // 1/gain = 0.6072529350 in Q1.31
    localparam logic [31:0] K_Q = 32'd1304065748;

    function automatic logic [31:0] k_q_scaled(input int width);
        if (width >= 32)
            return K_Q;
        return (K_Q + (32'd1 << (31 - width))) >> (32 - width);
    endfunction

    typedef enum logic [1:0] {IDLE, RUN, COMP, DONE} cordic_state_t;
`else
    typedef enum logic [1:0] {IDLE, RUN, DONE} cordic_state_t;
`endif

endpackage

// File: rtl/cordic_iter_stage.sv
// rtl/cordic_iter_stage.sv - one combinational vectoring-mode CORDIC micro-rotation
module cordic_iter_stage
    import cordic_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int AWIDTH = 20,
    parameter int SW     = 4
) (
    input  logic signed [WIDTH-1:0] x,
    input  logic signed [WIDTH-1:0] y,
    input  logic [AWIDTH-1:0]       z,
    input  logic [SW-1:0]           shift,
    output logic signed [WIDTH-1:0] x_next,
    output logic signed [WIDTH-1:0] y_next,
    output logic [AWIDTH-1:0]       z_next
);

    logic signed [WIDTH-1:0] x_sh;
    logic signed [WIDTH-1:0] y_sh;
    logic [AWIDTH-1:0]       atan_i;

    always_comb begin
        x_sh   = x >>> shift;
        y_sh   = y >>> shift;
        atan_i = AWIDTH'(atan_entry(5'(shift), AWIDTH));
        // rotate toward y = 0; sums wrap with no saturation
        if (!y[WIDTH-1]) begin
            x_next = x + y_sh;
            y_next = y - x_sh;
            z_next = z + atan_i;
        end else begin
            x_next = x - y_sh;
            y_next = y + x_sh;
            z_next = z - atan_i;
        end
    end

endmodule

// File: rtl/cordic_seq.sv
// rtl/cordic_seq.sv - iterative CORDIC vectoring engine; CORDIC_SEQ_GAIN_COMP_EN adds a 1/gain COMP step
module cordic_seq
    import cordic_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int AWIDTH = 20,
    parameter int ITER   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  xi,
    input  logic [WIDTH-1:0]  yi,
    input  logic [AWIDTH-1:0] zi,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  xo,
    output logic [WIDTH-1:0]  yo,
    output logic [AWIDTH-1:0] zo
);

    localparam int            SW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [SW-1:0] LAST = SW'(ITER - 1);

    cordic_state_t           state;
    logic [SW-1:0]           iter;
    logic signed [WIDTH-1:0] x;
    logic signed [WIDTH-1:0] y;
    logic [AWIDTH-1:0]       z;
    logic signed [WIDTH-1:0] x_nx;
    logic signed [WIDTH-1:0] y_nx;
    logic [AWIDTH-1:0]       z_nx;
    logic                    idle_q;
    logic                    done_q;

    cordic_iter_stage #(
        .WIDTH  (WIDTH),
        .AWIDTH (AWIDTH),
        .SW     (SW)
    ) u_stage (
        .x      (x),
        .y      (y),
        .z      (z),
        .shift  (iter),
        .x_next (x_nx),
        .y_next (y_nx),
        .z_next (z_nx)
    );

    // handshakes are masked while frozen so nothing completes with ena low
    assign in_ready  = idle_q & ena;
    assign out_valid = done_q & ena;

`ifdef CORDIC_SEQ_GAIN_COMP_EN
    localparam logic signed [WIDTH-1:0] K_W = WIDTH'(k_q_scaled(WIDTH));

    logic signed [2*WIDTH-1:0] x_prod;
    logic signed [2*WIDTH-1:0] y_prod;
    logic signed [WIDTH-1:0]   x_comp;
    logic signed [WIDTH-1:0]   y_comp;

    assign x_prod = x * K_W;
    assign y_prod = y * K_W;
    assign x_comp = WIDTH'(x_prod >>> (WIDTH - 1));
    assign y_comp = WIDTH'(y_prod >>> (WIDTH - 1));
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            iter   <= '0;
            x      <= '0;
            y      <= '0;
            z      <= '0;
            xo     <= '0;
            yo     <= '0;
            zo     <= '0;
            idle_q <= 1'b1;
            done_q <= 1'b0;
        end else if (ena) begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x      <= xi;
                        y      <= yi;
                        z      <= zi;
                        iter   <= '0;
                        idle_q <= 1'b0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    x    <= x_nx;
                    y    <= y_nx;
                    z    <= z_nx;
                    iter <= (iter == LAST) ? '0 : iter + 1'b1;
                    if (iter == LAST) begin
`ifdef CORDIC_SEQ_GAIN_COMP_EN
                        state  <= COMP;
`else
                        xo     <= x_nx;
                        yo     <= y_nx;
                        zo     <= z_nx;
                        done_q <= 1'b1;
                        state  <= DONE;
`endif
                    end
                end
`ifdef CORDIC_SEQ_GAIN_COMP_EN
                COMP: begin
                    x      <= x_comp;
                    y      <= y_comp;
                    xo     <= x_comp;
                    yo     <= y_comp;
                    zo     <= z;
                    done_q <= 1'b1;
                    state  <= DONE;
                end
`endif
                DONE: begin
                    if (out_ready) begin
                        done_q <= 1'b0;
                        idle_q <= 1'b1;
                        state  <= IDLE;
                    end
                end
                default: begin
                    idle_q <= 1'b1;
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule
